// File: rtl/seq_mul_sel_if.sv
// Operand, control and result bundle for the sequential multiply-and-select block.
// The master side supplies operands and control. The slave side returns status and the product.
interface seq_mul_sel_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   c;
  logic [WIDTH-1:0]   d;
  logic               sel;
  logic               en_n;
  logic               start;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] y;

  modport master (
    output a, b, c, d, sel, en_n, start,
    input  busy, done, y
  );

  modport slave (
    input  a, b, c, d, sel, en_n, start,
    output busy, done, y
  );
endinterface

// File: rtl/seq_mul_sel.sv
// Shift-add unsigned multiplier that computes A*B or C*D, selected by sel when start is accepted.
// It runs WIDTH iterations per product. The result is held until the next completed multiply.
//
// state | meaning
// IDLE  | waiting for start with en_n low; operands are latched on acceptance
// RUN   | one shift-add iteration per clock; en_n high aborts without an update
// DONE  | single-cycle done pulse after the product register is loaded
module seq_mul_sel #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_mul_sel_if.slave  bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    mcand, mcand_nxt;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [PW-1:0]    acc, acc_nxt;
  logic [PW-1:0]    acc_sum;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [PW-1:0]    prod, prod_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      prod   <= '0;
    end else begin
      state  <= state_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      prod   <= prod_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    prod_nxt   = prod;
    acc_sum    = acc + (mplier[0] ? mcand : '0);

    unique case (state)
      IDLE: begin
        if (bus.start && !bus.en_n) begin
          mcand_nxt  = {{WIDTH{1'b0}}, (bus.sel ? bus.c : bus.a)};
          mplier_nxt = bus.sel ? bus.d : bus.b;
          acc_nxt    = '0;
          cnt_nxt    = '0;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        // An abort leaves the datapath frozen; the next accepted start reloads it anyway.
        if (bus.en_n) begin
          state_nxt = IDLE;
        end else begin
          acc_nxt    = acc_sum;
          mcand_nxt  = mcand << 1;
          mplier_nxt = mplier >> 1;
          cnt_nxt    = cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            prod_nxt  = acc_sum;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.y    = bus.en_n ? '0 : prod;

endmodule

// File: tb/tb_seq_mul_sel.sv
// Directed and randomized bench for seq_mul_sel at WIDTH=4 and WIDTH=8.
// Expected products come from plain integer multiplication. Timing is taken from the stated start-to-done latency.
module tb_seq_mul_sel;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   last4;
  int   last8;

  seq_mul_sel_if #(.WIDTH(4)) bus4 ();
  seq_mul_sel_if #(.WIDTH(8)) bus8 ();

  seq_mul_sel #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  seq_mul_sel #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0 plain, 1 operands scrambled mid-run, 2 extra start pulse mid-run, 3 start held as a level
  task automatic run4(input int a, input int b, input int c, input int d, input bit s, input int mode);
    int exp;
    exp = s ? c * d : a * b;
    bus4.a = 4'(a); bus4.b = 4'(b); bus4.c = 4'(c); bus4.d = 4'(d);
    bus4.sel = s; bus4.start = 1'b1;
    @(negedge clk);
    if (mode != 3) bus4.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("w4 busy during run", 32'(bus4.busy), 32'd1);
      chk("w4 no done during run", 32'(bus4.done), 32'd0);
      chk("w4 y holds previous", 32'(bus4.y), 32'(last4));
      if (mode == 1 && i == 1) begin
        bus4.a = 4'($urandom); bus4.b = 4'($urandom);
        bus4.c = 4'($urandom); bus4.d = 4'($urandom);
        bus4.sel = ~s;
      end
      if (mode == 2 && i == 1) bus4.start = 1'b1;
      if (mode == 2 && i == 2) bus4.start = 1'b0;
      @(negedge clk);
    end
    chk("w4 done pulse", 32'(bus4.done), 32'd1);
    chk("w4 busy low at done", 32'(bus4.busy), 32'd0);
    chk("w4 product", 32'(bus4.y), 32'(exp));
    last4 = exp;
    if (mode == 3) begin
      @(negedge clk);
      chk("w4 start ignored in done", 32'(bus4.busy), 32'd0);
      @(negedge clk);
      chk("w4 start accepted after done", 32'(bus4.busy), 32'd1);
      bus4.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("w4 level restart done", 32'(bus4.done), 32'd1);
      chk("w4 level restart product", 32'(bus4.y), 32'(exp));
    end
    @(negedge clk);
    chk("w4 done single cycle", 32'(bus4.done), 32'd0);
    chk("w4 y held", 32'(bus4.y), 32'(exp));
    if (mode == 2) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("w4 no second done", 32'(bus4.done | bus4.busy), 32'd0);
      end
    end
  endtask

  task automatic run8(input int a, input int b, input int c, input int d, input bit s);
    int exp;
    exp = s ? c * d : a * b;
    bus8.a = 8'(a); bus8.b = 8'(b); bus8.c = 8'(c); bus8.d = 8'(d);
    bus8.sel = s; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("w8 busy during run", 32'(bus8.busy), 32'd1);
      chk("w8 no done during run", 32'(bus8.done), 32'd0);
      @(negedge clk);
    end
    chk("w8 done pulse", 32'(bus8.done), 32'd1);
    chk("w8 busy low at done", 32'(bus8.busy), 32'd0);
    chk("w8 product", 32'(bus8.y), 32'(exp));
    last8 = exp;
    @(negedge clk);
    chk("w8 done single cycle", 32'(bus8.done), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; last4 = 0; last8 = 0;
    rst_n = 1'b0;
    bus4.a = '0; bus4.b = '0; bus4.c = '0; bus4.d = '0;
    bus4.sel = 1'b0; bus4.en_n = 1'b0; bus4.start = 1'b0;
    bus8.a = '0; bus8.b = '0; bus8.c = '0; bus8.d = '0;
    bus8.sel = 1'b0; bus8.en_n = 1'b0; bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(bus4.busy), 32'd0);
    chk("reset done", 32'(bus4.done), 32'd0);
    chk("reset y", 32'(bus4.y), 32'd0);
    chk("reset y w8", 32'(bus8.y), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run4(3, 5, 0, 0, 1'b0, 0);
    run4(0, 0, 15, 15, 1'b1, 1);
    run4(2, 3, 9, 9, 1'b0, 2);

    // abort 7*7 in the third busy cycle
    bus4.a = 4'd7; bus4.b = 4'd7; bus4.sel = 1'b0; bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    chk("abort busy c1", 32'(bus4.busy), 32'd1);
    @(negedge clk);
    chk("abort busy c2", 32'(bus4.busy), 32'd1);
    @(negedge clk);
    chk("abort busy c3", 32'(bus4.busy), 32'd1);
    bus4.en_n = 1'b1;
    #1;
    chk("abort y gated", 32'(bus4.y), 32'd0);
    @(negedge clk);
    chk("abort busy dropped", 32'(bus4.busy), 32'd0);
    chk("abort y still gated", 32'(bus4.y), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("abort no done", 32'(bus4.done), 32'd0);
      @(negedge clk);
    end
    bus4.start = 1'b1;
    @(negedge clk);
    chk("start ignored while disabled", 32'(bus4.busy), 32'd0);
    bus4.start = 1'b0;
    bus4.en_n = 1'b0;
    #1;
    chk("abort keeps old product", 32'(bus4.y), 32'(last4));
    @(negedge clk);

    // async reset between edges mid-run
    bus4.a = 4'd5; bus4.b = 4'd5; bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset busy", 32'(bus4.busy), 32'd0);
    chk("async reset done", 32'(bus4.done), 32'd0);
    chk("async reset y", 32'(bus4.y), 32'd0);
    last4 = 0; last8 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post reset no done", 32'(bus4.done), 32'd0);
    run4(9, 9, 0, 0, 1'b0, 0);

    run4(0, 15, 0, 0, 1'b0, 0);
    run4(0, 0, 15, 1, 1'b1, 0);
    run4(1, 1, 0, 0, 1'b0, 3);
    run8(255, 255, 0, 0, 1'b0);
    run8(0, 0, 200, 3, 1'b1);

    for (int n = 0; n < 20; n++) begin
      run4(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)),
           int'($urandom_range(15)), 1'($urandom), int'($urandom_range(3)));
    end
    for (int n = 0; n < 8; n++) begin
      run8(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)),
           int'($urandom_range(255)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
